// File: rtl/sumator_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package sumator_pkg;

   localparam int unsigned WIDTH_DEF = 8;
   localparam int unsigned DIGIT_DEF = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned n_digits(input int unsigned w, input int unsigned d);
      return w / d;
   endfunction

   // A single-digit operation still needs a one-bit counter.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fac.sv
// One-bit full-adder cell.
module fac (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/sumator_cifra.sv
// DIGIT-bit ripple slice; also exposes the carry into its top bit for overflow.
module sumator_cifra #(
   parameter int unsigned DIGIT = 2
) (
   input  logic [DIGIT-1:0] a_i,
   input  logic [DIGIT-1:0] b_i,
   input  logic             c_i,
   output logic [DIGIT-1:0] s_o,
   output logic             c_o,
   output logic             c_msb_o
);

   logic [DIGIT:0] c;

   assign c[0] = c_i;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      fac u_fac (
         .a_i (a_i[i]),
         .b_i (b_i[i]),
         .c_i (c[i]),
         .s_o (s_o[i]),
         .c_o (c[i+1])
      );
   end

   assign c_o     = c[DIGIT];
   assign c_msb_o = c[DIGIT-1];

endmodule

// File: rtl/sumator_scazator_secvential.sv
// Digit-serial two's-complement adder/subtractor, LSB first, start/done handshake.
module sumator_scazator_secvential
   import sumator_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned DIGIT = DIGIT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic             acc,
   input  logic [WIDTH-1:0] in_1,
   input  logic [WIDTH-1:0] in_2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s_mod,
   output logic             Cout,
   output logic             Ovf,
   output logic             Zero
);

   localparam int unsigned N  = n_digits(WIDTH, DIGIT);
   localparam int unsigned CW = cnt_width(N);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, s_q, s_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d;
   logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
   logic             busy_q, busy_d, done_q, done_d;

   logic [DIGIT-1:0] dig_sum;
   logic             dig_cout, dig_cmsb;
   logic [WIDTH-1:0] r_shift;
   logic             last;

   sumator_cifra #(.DIGIT(DIGIT)) u_cifra (
      .a_i     (a_q[DIGIT-1:0]),
      .b_i     (b_q[DIGIT-1:0]),
      .c_i     (c_q),
      .s_o     (dig_sum),
      .c_o     (dig_cout),
      .c_msb_o (dig_cmsb)
   );

   // New sum digit enters at the MSB end so the finished word lands in place.
   assign r_shift = (r_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
   assign last    = (cnt_q == CW'(N - 1));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      s_d     = s_q;
      c_d     = c_q;
      cnt_d   = cnt_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = acc ? s_q : in_1;
               b_d     = in_2 ^ {WIDTH{sub}};
               c_d     = sub;
               cnt_d   = '0;
               r_d     = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d   = a_q >> DIGIT;
            b_d   = b_q >> DIGIT;
            r_d   = r_shift;
            c_d   = dig_cout;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               s_d     = r_shift;
               cout_d  = dig_cout;
               ovf_d   = dig_cout ^ dig_cmsb;
               zero_d  = (r_shift == '0);
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         s_q     <= '0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         s_q     <= s_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign s_mod = s_q;
   assign Cout  = cout_q;
   assign Ovf   = ovf_q;
   assign Zero  = zero_q;

endmodule

// File: tb/tb_sumator_scazator_secvential.sv
// Randomized bench with a transaction-level reference model and a parameter sweep.
module tb_sumator_scazator_secvential;

   localparam int unsigned N = 4;

   logic clk = 1'b0;
   logic rst_n, start, sub, acc;
   logic [7:0] in_1, in_2, s_mod;
   logic busy, done, Cout, Ovf, Zero;

   logic sw_start, sw_sub;
   logic [15:0] sw_in1, sw_in2;
   logic [3:0] sw_busy, sw_done, sw_c, sw_o, sw_z;
   logic [7:0] s_d1, s_d4, s_d8;
   logic [15:0] s_w16;
   logic [15:0] sw_s [4];
   int unsigned wd [4] = '{8, 8, 8, 16};
   int unsigned ln [4] = '{8, 2, 1, 4};

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   sumator_scazator_secvential #(.WIDTH(8), .DIGIT(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .acc(acc),
      .in_1(in_1), .in_2(in_2), .busy(busy), .done(done),
      .s_mod(s_mod), .Cout(Cout), .Ovf(Ovf), .Zero(Zero));

   sumator_scazator_secvential #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .start(sw_start), .sub(sw_sub), .acc(1'b0),
      .in_1(sw_in1[7:0]), .in_2(sw_in2[7:0]), .busy(sw_busy[0]), .done(sw_done[0]),
      .s_mod(s_d1), .Cout(sw_c[0]), .Ovf(sw_o[0]), .Zero(sw_z[0]));

   sumator_scazator_secvential #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .start(sw_start), .sub(sw_sub), .acc(1'b0),
      .in_1(sw_in1[7:0]), .in_2(sw_in2[7:0]), .busy(sw_busy[1]), .done(sw_done[1]),
      .s_mod(s_d4), .Cout(sw_c[1]), .Ovf(sw_o[1]), .Zero(sw_z[1]));

   sumator_scazator_secvential #(.WIDTH(8), .DIGIT(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .start(sw_start), .sub(sw_sub), .acc(1'b0),
      .in_1(sw_in1[7:0]), .in_2(sw_in2[7:0]), .busy(sw_busy[2]), .done(sw_done[2]),
      .s_mod(s_d8), .Cout(sw_c[2]), .Ovf(sw_o[2]), .Zero(sw_z[2]));

   sumator_scazator_secvential #(.WIDTH(16), .DIGIT(4)) u_w16 (
      .clk(clk), .rst_n(rst_n), .start(sw_start), .sub(sw_sub), .acc(1'b0),
      .in_1(sw_in1), .in_2(sw_in2), .busy(sw_busy[3]), .done(sw_done[3]),
      .s_mod(s_w16), .Cout(sw_c[3]), .Ovf(sw_o[3]), .Zero(sw_z[3]));

   assign sw_s[0] = {8'h00, s_d1};
   assign sw_s[1] = {8'h00, s_d4};
   assign sw_s[2] = {8'h00, s_d8};
   assign sw_s[3] = s_w16;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Returns {zero, ovf, cout, result[15:0]} from plain integer arithmetic.
   function automatic logic [18:0] ref_op(input int unsigned w, input logic [15:0] a,
                                          input logic [15:0] b, input logic s);
      longint m, ua, ub, sa, sb, r, sr, half;
      logic c, o, z;
      m    = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ua   = longint'(a) & m;
      ub   = longint'(b) & m;
      sa   = (ua >= half) ? ua - (m + 1) : ua;
      sb   = (ub >= half) ? ub - (m + 1) : ub;
      if (s) begin
         r  = (ua - ub) & m;
         c  = (ua >= ub);
         sr = sa - sb;
      end else begin
         r  = (ua + ub) & m;
         c  = ((ua + ub) > m);
         sr = sa + sb;
      end
      o = (sr >= half) || (sr < -half);
      z = (r == 0);
      return {z, o, c, 16'(r)};
   endfunction

   // Transaction-level model of the 8-bit/2-digit instance.
   logic m_busy = 1'b0, m_done = 1'b0, m_c = 1'b0, m_o = 1'b0, m_z = 1'b0;
   logic [7:0] m_s = 8'h00;
   logic [18:0] m_pend = '0;
   int m_rem = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_done = 1'b0; m_s = 8'h00;
         m_c = 1'b0; m_o = 1'b0; m_z = 1'b0; m_rem = 0;
      end else if (m_busy) begin
         m_rem--;
         if (m_rem == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_s = m_pend[7:0];
            m_c = m_pend[16];
            m_o = m_pend[17];
            m_z = m_pend[18];
         end
      end else if (start) begin
         m_pend = ref_op(8, {8'h00, acc ? m_s : in_1}, {8'h00, in_2}, sub);
         m_busy = 1'b1;
         m_done = 1'b0;
         m_rem  = N;
      end else begin
         m_done = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("s_mod", s_mod, m_s);
         chk("Cout", Cout, m_c);
         chk("Ovf", Ovf, m_o);
         chk("Zero", Zero, m_z);
      end
   end

   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk("done_seen", done, 1'b1);
   endtask

   task automatic op(input logic [7:0] a, input logic [7:0] b, input logic s, input logic ac,
                     input logic [7:0] es, input logic ec, input logic eo, input logic ez,
                     input string nm);
      int lat;
      @(negedge clk);
      in_1 = a; in_2 = b; sub = s; acc = ac; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      chk({nm, "_lat"}, lat, N);
      chk({nm, "_s"}, s_mod, es);
      chk({nm, "_c"}, Cout, ec);
      chk({nm, "_o"}, Ovf, eo);
      chk({nm, "_z"}, Zero, ez);
   endtask

   task automatic sweep_op(input logic [15:0] a, input logic [15:0] b, input logic s);
      logic [3:0] seen;
      logic [18:0] r;
      int lat;
      @(negedge clk);
      sw_in1 = a; sw_in2 = b; sw_sub = s; sw_start = 1'b1;
      @(negedge clk);
      sw_start = 1'b0;
      seen = '0;
      lat = 0;
      while (seen != 4'hF && lat < 20) begin
         @(negedge clk);
         lat++;
         for (int k = 0; k < 4; k++) begin
            if (sw_done[k] && !seen[k]) begin
               seen[k] = 1'b1;
               r = ref_op(wd[k], a, b, s);
               chk("sw_lat", lat, ln[k]);
               chk("sw_s", sw_s[k], r[15:0]);
               chk("sw_c", sw_c[k], r[16]);
               chk("sw_o", sw_o[k], r[17]);
               chk("sw_z", sw_z[k], r[18]);
               chk("sw_busy", sw_busy[k], 1'b0);
            end
         end
      end
      chk("sw_all_done", seen, 4'hF);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int lat;
      logic [15:0] cv [6] = '{16'h0000, 16'hFFFF, 16'h8080, 16'h8000, 16'h0101, 16'h7F7F};
      rst_n = 1'b0; start = 1'b0; sub = 1'b0; acc = 1'b0; in_1 = '0; in_2 = '0;
      sw_start = 1'b0; sw_sub = 1'b0; sw_in1 = '0; sw_in2 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_s", s_mod, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_flags", {Cout, Ovf, Zero}, 3'b000);
      chk("rst_sw_busy", sw_busy, 4'h0);
      chk("rst_sw_s16", s_w16, 16'h0000);
      rst_n = 1'b1;

      op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, "add");
      op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, "add_ovf");
      op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "add_wrap");
      op(8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, "sub_neg");
      op(8'h07, 8'h05, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0, "sub_pos");
      op(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, "sub_ovf");
      op(8'h33, 8'h33, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "sub_zero");

      // Back-to-back accumulate with a stray start during RUN.
      op(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, "acc_base");
      start = 1'b1; acc = 1'b1; sub = 1'b0; in_1 = 8'hAA; in_2 = 8'h05;
      @(negedge clk);
      chk("b2b_busy", busy, 1'b1);
      start = 1'b0;
      lat = 0;
      @(negedge clk);
      lat++;
      start = 1'b1; acc = 1'b0; sub = 1'b1; in_1 = 8'h99; in_2 = 8'h77;
      @(negedge clk);
      lat++;
      start = 1'b0;
      while (!done && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk("acc_lat", lat, N);
      chk("acc_s", s_mod, 8'h35);
      @(negedge clk);
      chk("stray_ignored", busy, 1'b0);

      // Abort in the second RUN cycle.
      start = 1'b1; acc = 1'b0; sub = 1'b0; in_1 = 8'h21; in_2 = 8'h11;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_s", s_mod, 8'h00);
      chk("abort_busy", busy, 1'b0);
      chk("abort_flags", {done, Cout, Ovf, Zero}, 4'h0);
      repeat (6) begin
         @(negedge clk);
         chk("abort_no_done", done, 1'b0);
      end
      op(8'h21, 8'h11, 1'b0, 1'b0, 8'h32, 1'b0, 1'b0, 1'b0, "post_abort");

      // Random traffic against the model, sometimes back-to-back or with stray starts.
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         in_1 = 8'($urandom); in_2 = 8'($urandom);
         sub = 1'($urandom); acc = ($urandom_range(0, 3) == 0);
         start = 1'b1;
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         in_1 = 8'($urandom); in_2 = 8'($urandom);
         @(negedge clk);
         start = 1'b0;
         wait_done(lat);
         start = ($urandom_range(0, 2) == 0);
         acc = 1'($urandom);
         in_2 = 8'($urandom);
         if (start) begin
            @(negedge clk);
            start = 1'b0;
            wait_done(lat);
         end
      end

      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 6; j += 2) begin
            sweep_op(cv[i], cv[j], 1'b0);
            sweep_op(cv[i], cv[j], 1'b1);
         end
      end
      for (int i = 0; i < 20; i++)
         sweep_op(16'($urandom), 16'($urandom), 1'($urandom));

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sumator_scazator_secvential.md
# sumator_scazator_secvential

Parametrised, digit-serial two's-complement adder/subtractor with a start/done handshake. It processes `DIGIT` bits per clock, LSB first, over `WIDTH/DIGIT` cycles. It adds signed overflow and zero flags and an accumulate mode to the combinational 8-bit add/sub datapath. It sits in the arithmetic unit wherever area matters more than latency, feeding the result/flag registers.

## Interface
- `WIDTH`, default 8: operand/result width; must be a multiple of `DIGIT`.
- `DIGIT`, default 2: bits processed per cycle, range 1..`WIDTH`.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `start`, input, 1: request an operation; sampled only when idle or done.
- `sub`, input, 1: 0 = in_1 + in_2, 1 = in_1 − in_2; captured with `start`.
- `acc`, input, 1: 1 = use current `s_mod` as operand A instead of `in_1`; captured with `start`.
- `in_1`, input, `WIDTH`: operand A.
- `in_2`, input, `WIDTH`: operand B.
- `busy`, output, 1: operation in progress.
- `done`, output, 1: one-cycle pulse when results update.
- `s_mod`, output, `WIDTH`: result, registered, held until the next completion.
- `Cout`, output, 1: carry out of the MSB. In subtract mode, 1 = no borrow.
- `Ovf`, output, 1: signed overflow, equal to carry into the MSB XOR carry out.
- `Zero`, output, 1: `s_mod` == 0.

## Operation
- Let N = `WIDTH/DIGIT`. The state machine has three states: IDLE, RUN, DONE.
- **Accepting a request.** In IDLE or DONE, `start`=1 does the following:
  - captures A (`in_1`, or `s_mod` if `acc`=1) and B XOR {`WIDTH`{`sub`}};
  - initialises the carry register to `sub` and the digit counter to 0;
  - moves to RUN.
- **IDLE/DONE without a request.** DONE goes to IDLE; IDLE stays in IDLE.
- **RUN.** Each cycle:
  - add the low `DIGIT` bits of A and B plus the carry register;
  - shift the sum digit into the result shift register from the MSB side;
  - shift A and B right by `DIGIT`;
  - store the digit carry-out;
  - increment the counter.
- **Last digit of RUN** (counter = N−1) loads `s_mod`, `Cout`, `Ovf` and `Zero` from the completed sum, then goes to DONE.
- **`start` during RUN** is ignored. Operands and mode are not re-sampled.
- **`busy`** = (state == RUN). **`done`** = (state == DONE).
- **Carry/overflow rules.**
  - `Ovf` uses the carry into bit `WIDTH`−1, taken from inside the final digit slice.
  - When `DIGIT`=1, that carry is the carry register value at the start of the final cycle.
- **Reset** (`rst_n`=0 at an edge) does the following, even mid-RUN:
  - state goes to IDLE;
  - `s_mod`, `Cout`, `Ovf`, `Zero`, `busy`, `done` and all internal registers go to 0;
  - the aborted operation never produces `done`.
- **Arithmetic** is modulo 2^`WIDTH`. Results match the combinational adder/subtractor bit-for-bit for all operands.

## Timing
- Start accepted at edge E0 → `busy`=1 from E0 to EN → `done`=1 and new outputs visible from EN to EN+1.
- Latency is N cycles from the accepting edge to results. Throughput is one operation per N+1 cycles.
- Back-to-back operation: `start` held during DONE is accepted at EN+1, so `busy` rises with no idle gap.
- `acc`=1 accepted in DONE uses the result just produced.
- Outputs change only at the completion edge or at reset; they are stable in all other cycles.

## Structure
- **Shared package `sumator_pkg`:**
  - state enum {IDLE, RUN, DONE};
  - localparam N = `WIDTH/DIGIT` helper;
  - counter width = $clog2(N) (minimum 1).
- **Sub-module `sumator_cifra`:** a `DIGIT`-bit ripple slice built from the existing `fac` full-adder cell. It has outputs for the sum, carry-out and carry into its MSB.
- The top level holds the FSM, shift registers, counter and output registers.

## Test plan
All scenarios use `WIDTH`=8, `DIGIT`=2, N=4 unless noted.
1. **Reset:** hold `rst_n`=0 for 2 cycles → all outputs 0 and `busy`=0. Then `start` with 0x12+0x34 → `done` 4 cycles after the accepting edge, `s_mod`=0x46, `Cout`=0, `Ovf`=0, `Zero`=0.
2. **Add overflow:** 0x7F+0x01 → 0x80, `Ovf`=1, `Cout`=0. Then 0xFF+0x01 → 0x00, `Cout`=1, `Ovf`=0, `Zero`=1.
3. **Subtract:**
   - 0x05−0x07 → 0xFE, `Cout`=0, `Ovf`=0;
   - 0x07−0x05 → 0x02, `Cout`=1;
   - 0x80−0x01 → 0x7F, `Cout`=1, `Ovf`=1;
   - 0x33−0x33 → 0x00, `Zero`=1, `Cout`=1.
4. **Accumulate, back-to-back, ignored start:**
   - 0x10+0x20 → 0x30;
   - `start` with `acc`=1, `in_2`=0x05 held through DONE → accepted immediately → 0x35;
   - a `start` pulsed during RUN with other operands has no effect.
5. **Reset mid-operation:** `rst_n`=0 at the second RUN cycle → next cycle all outputs 0, no `done` pulse. A fresh `start` afterwards completes normally.
6. **Parameter sweep:** `DIGIT` ∈ {1, 2, 4, 8}, with `WIDTH`=16 and `DIGIT`=4. Use random operands plus the all-0s, all-1s and 0x80…0 corner values → results and flags equal the reference model, and latency = `WIDTH/DIGIT`.
